// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out frame receiver: assembles WIDTH bits started by sof
// and presents each completed word in a holding register with a valid/ack handshake.
module shift_reg_sipo_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_base, w_ins;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid, r_busy, r_ferr, r_ovr;
  logic             w_complete, w_resync;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    w_resync    = 1'b0;
    // A start bit always begins from a clean register so no stale bits survive
    w_base      = sof ? '0 : r_shift;
    w_ins       = LSB_FIRST ? {sin, w_base[WIDTH-1:1]} : {w_base[WIDTH-2:0], sin};
    case (r_state)
      IDLE: begin
        if (sin_en && sof) begin
          w_shift_nxt = w_ins;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_en) begin
          w_shift_nxt = w_ins;
          if (sof) begin
            w_resync  = 1'b1;
            w_cnt_nxt = CW'(1);
          end else if (r_cnt == CW'(WIDTH - 1)) begin
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == SHIFT);
      r_ferr  <= w_resync;
    end
  end

  // An ack arriving with a completion frees the slot for the new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_complete) begin
      if (!r_valid || dout_ack) begin
        r_dout  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && dout_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Directed bench for shift_reg_sipo_rx: one LSB-first and one MSB-first instance,
// inputs driven on the falling edge and outputs sampled there too.
module tb_shift_reg_sipo_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin0, en0, sof0, ack0;
  logic       sin1, en1, sof1, ack1;
  logic [7:0] dout0, dout1;
  logic       valid0, busy0, ferr0, ovr0;
  logic       valid1, busy1, ferr1, ovr1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  shift_reg_sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin0), .sin_en(en0), .sof(sof0),
    .dout(dout0), .dout_valid(valid0), .dout_ack(ack0),
    .busy(busy0), .frame_err(ferr0), .overrun(ovr0)
  );

  shift_reg_sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .sin_en(en1), .sof(sof1),
    .dout(dout1), .dout_valid(valid1), .dout_ack(ack1),
    .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs to the selected instance; the other one idles
  task automatic step(input logic en, input logic s, input logic b, input logic a, input logic sel);
    @(negedge clk);
    {sin0, en0, sof0, ack0} = 4'b0;
    {sin1, en1, sof1, ack1} = 4'b0;
    if (sel) {sin1, en1, sof1, ack1} = {b, en, s, a};
    else     {sin0, en0, sof0, ack0} = {b, en, s, a};
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input logic sel,
                           input logic ack_last, input logic chk_ferr);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = sel ? w[7-i] : w[i];
      step(1'b1, (i == 0), b, ack_last && (i == 7), sel);
      if (i >= 1) check("busy in frame", sel ? busy1 : busy0, 1);
      if (chk_ferr && i == 1) check("frame_err pulse", ferr0, 1);
      if (chk_ferr && i == 2) check("frame_err one cycle", ferr0, 0);
      for (int g = 0; g < gap; g++) idle();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    {sin0, en0, sof0, ack0} = 4'b0;
    {sin1, en1, sof1, ack1} = 4'b0;
    #12;
    check("reset dout", dout0, 0);
    check("reset valid", valid0, 0);
    check("reset busy", busy0, 0);
    check("reset frame_err", ferr0, 0);
    check("reset overrun", ovr0, 0);
    check("reset dout msb", dout1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic byte
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    check("basic dout", dout0, 8'hA5);
    check("basic valid", valid0, 1);
    check("basic busy done", busy0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("ack clears valid", valid0, 0);
    check("ack keeps dout", dout0, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("ack while idle", valid0, 0);

    // Resync: partial frame then a new sof
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("partial busy", busy0, 1);
    check("no frame_err yet", ferr0, 0);
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b1);
    check("resync dout", dout0, 8'h3C);
    check("resync valid", valid0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped strobe with stray bits while idle
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("idle bits ignored busy", busy0, 0);
    check("idle bits ignored valid", valid0, 0);
    send_word(8'hA5, 2, 1'b0, 1'b0, 1'b0);
    check("gapped dout", dout0, 8'hA5);
    check("gapped valid", valid0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Ack coincident with completion
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    check("coinc first dout", dout0, 8'h11);
    send_word(8'h22, 0, 1'b0, 1'b1, 1'b0);
    check("coinc dout", dout0, 8'h22);
    check("coinc valid", valid0, 1);
    check("coinc no overrun", ovr0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("coinc ack valid", valid0, 0);

    // Overrun
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    check("ovr first dout", dout0, 8'h11);
    check("ovr not yet", ovr0, 0);
    send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
    check("ovr dout held", dout0, 8'h11);
    check("ovr set", ovr0, 1);
    check("ovr valid", valid0, 1);
    idle();
    check("ovr sticky", ovr0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("ovr ack valid", valid0, 0);
    send_word(8'h33, 0, 1'b0, 1'b0, 1'b0);
    check("ovr new dout", dout0, 8'h33);
    check("ovr still set", ovr0, 1);

    // Async reset mid-frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre-reset busy", busy0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async dout", dout0, 0);
    check("async valid", valid0, 0);
    check("async busy", busy0, 0);
    check("async overrun", ovr0, 0);
    check("async frame_err", ferr0, 0);
    #1 rst_n = 1'b1;
    send_word(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    check("post-reset dout", dout0, 8'h5A);
    check("post-reset valid", valid0, 1);
    check("post-reset overrun", ovr0, 0);

    // MSB-first instance
    check("msb idle dout", dout1, 0);
    send_word(8'h5A, 0, 1'b1, 1'b0, 1'b0);
    check("msb dout", dout1, 8'h5A);
    check("msb valid", valid1, 1);
    check("msb busy done", busy1, 0);
    check("lsb untouched", dout0, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
